// File: rtl/hififo_pkg.sv
// rtl/hififo_pkg.sv - shared state encoding, register offsets and control bits for the DMA write path
package hififo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Word offsets from the block's PIO base address
  localparam logic [12:0] OFF_BASE    = 13'd0;
  localparam logic [12:0] OFF_COUNT   = 13'd1;
  localparam logic [12:0] OFF_CONTROL = 13'd2;

  // CONTROL write bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

endpackage

// File: rtl/dma_write_sequencer.sv
// rtl/dma_write_sequencer.sv - turns FIFO words into sequential host memory-write requests under PIO control
module dma_write_sequencer
  import hififo_pkg::*;
#(
  parameter logic [12:0] REG_BASE = 13'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pio_write_valid,
  input  logic        pio_read_valid,
  input  logic [12:0] pio_address,
  input  logic [63:0] pio_write_data,
  output logic [63:0] pio_read_data,
  input  logic [63:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_ready,
  output logic        write_request_valid,
  output logic [63:0] write_request_address,
  output logic [63:0] write_request_data,
  input  logic        write_request_ready,
  output logic        busy,
  output logic        interrupt
);

  localparam logic [12:0] ADDR_BASE    = REG_BASE + OFF_BASE;
  localparam logic [12:0] ADDR_COUNT   = REG_BASE + OFF_COUNT;
  localparam logic [12:0] ADDR_CONTROL = REG_BASE + OFF_CONTROL;

  state_t      state, state_next;
  logic [63:0] address;
  logic [31:0] remaining;
  logic [31:0] words_sent;
  logic        done;
  logic        aborted;
  logic        abort_req;

  logic base_write, count_write, control_write;
  logic start, abort, clear;
  logic request_free, transfer;

  assign base_write    = pio_write_valid && (pio_address == ADDR_BASE);
  assign count_write   = pio_write_valid && (pio_address == ADDR_COUNT);
  assign control_write = pio_write_valid && (pio_address == ADDR_CONTROL);
  assign start         = control_write && pio_write_data[CTRL_START];
  assign abort         = control_write && pio_write_data[CTRL_ABORT];
  assign clear         = control_write && pio_write_data[CTRL_CLEAR];

  // Output slot is free when empty or being drained this cycle
  assign request_free = !write_request_valid || write_request_ready;
  assign transfer     = fifo_valid && fifo_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (remaining != 32'd0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (remaining == 32'd0 && request_free) state_next = abort_req ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ST_RUN);
    fifo_ready = busy && (remaining != 32'd0) && request_free;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      address               <= 64'd0;
      remaining             <= 32'd0;
      words_sent            <= 32'd0;
      done                  <= 1'b0;
      aborted               <= 1'b0;
      abort_req             <= 1'b0;
      interrupt             <= 1'b0;
      write_request_valid   <= 1'b0;
      write_request_address <= 64'd0;
      write_request_data    <= 64'd0;
      pio_read_data         <= 64'd0;
    end else begin
      if (!busy && base_write)  address   <= {pio_write_data[63:3], 3'b000};
      if (!busy && count_write) remaining <= pio_write_data[31:0];

      if (transfer) begin
        address               <= address + 64'd8;
        remaining             <= remaining - 32'd1;
        write_request_valid   <= 1'b1;
        write_request_address <= address;
        write_request_data    <= fifo_data;
      end else if (write_request_ready) begin
        write_request_valid <= 1'b0;
      end

      // Clear is applied before the increment so start+clear restarts the tally
      if (transfer)   words_sent <= (clear ? 32'd0 : words_sent) + 32'd1;
      else if (clear) words_sent <= 32'd0;

      if (clear)             done    <= 1'b0;
      if (state == ST_DONE)  done    <= 1'b1;
      if (clear)             aborted <= 1'b0;

      if (busy && abort) begin
        remaining <= 32'd0;
        aborted   <= 1'b1;
        abort_req <= 1'b1;
      end else if (state == ST_IDLE && start) begin
        abort_req <= 1'b0;
      end

      interrupt <= (state == ST_DONE);

      if (pio_read_valid) begin
        if (pio_address == ADDR_BASE)
          pio_read_data <= address;
        else if (pio_address == ADDR_COUNT)
          pio_read_data <= {32'd0, remaining};
        else if (pio_address == ADDR_CONTROL)
          pio_read_data <= {words_sent, 29'd0, aborted, done, busy};
      end
    end
  end

endmodule

// File: tb/tb_dma_write_sequencer.sv
// tb/tb_dma_write_sequencer.sv - scoreboard bench for dma_write_sequencer
module tb_dma_write_sequencer;

  localparam logic [12:0] BASE_A = 13'd16;
  localparam logic [12:0] COUNT_A = 13'd17;
  localparam logic [12:0] CTRL_A = 13'd18;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pio_write_valid = 1'b0;
  logic        pio_read_valid = 1'b0;
  logic [12:0] pio_address = 13'd0;
  logic [63:0] pio_write_data = 64'd0;
  logic [63:0] pio_read_data;
  logic [63:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic        write_request_valid;
  logic [63:0] write_request_address;
  logic [63:0] write_request_data;
  logic        write_request_ready;
  logic        busy;
  logic        interrupt;

  dma_write_sequencer #(.REG_BASE(13'd16)) dut (
    .clock(clock), .reset(reset),
    .pio_write_valid(pio_write_valid), .pio_read_valid(pio_read_valid),
    .pio_address(pio_address), .pio_write_data(pio_write_data), .pio_read_data(pio_read_data),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .write_request_valid(write_request_valid), .write_request_address(write_request_address),
    .write_request_data(write_request_data), .write_request_ready(write_request_ready),
    .busy(busy), .interrupt(interrupt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } req_t;

  int   n_checks = 0;
  int   n_fail = 0;
  req_t exp_q[$];
  logic [63:0] data_arr [0:127];
  int   job_gen = 0;
  int   fifo_limit = 0;
  int   fifo_gate_pct = 100;
  int   ready_mode = 0;
  int   stall_at = 0;
  int   stall_len = 0;
  int   acc_count = 0;
  int   int_count = 0;
  int   cyc = 0;
  int   acc_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pio_write(input logic [12:0] a, input logic [63:0] d);
    pio_address = a;
    pio_write_data = d;
    pio_write_valid = 1'b1;
    step();
    pio_write_valid = 1'b0;
  endtask

  task automatic pio_read(input logic [12:0] a, output logic [63:0] d);
    pio_address = a;
    pio_read_valid = 1'b1;
    step();
    pio_read_valid = 1'b0;
    d = pio_read_data;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", budget);
    end
    repeat (3) step();
  endtask

  // Reference: word i of a job lands at (base & ~7) + 8*i carrying the i-th source word
  task automatic prepare_job(input logic [63:0] base, input int count);
    for (int i = 0; i < 128; i++) data_arr[i] = {$urandom, $urandom};
    for (int i = 0; i < count; i++)
      exp_q.push_back({(base & ~64'h7) + 64'(i) * 64'd8, data_arr[i]});
  endtask

  task automatic run_job(input logic [63:0] base, input int count, input int rmode, input int gate);
    logic [63:0] rd;
    int ic0;
    prepare_job(base, count);
    fifo_limit = count;
    fifo_gate_pct = gate;
    ready_mode = rmode;
    job_gen++;
    ic0 = int_count;
    pio_write(BASE_A, base);
    pio_write(COUNT_A, 64'(count));
    pio_write(CTRL_A, 64'h5);
    wait_idle(3000);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("irq_count", 64'(int_count - ic0), 64'd1);
    pio_read(CTRL_A, rd);
    check("status", rd, {32'(count), 29'd0, 3'b010});
    pio_read(BASE_A, rd);
    check("final_addr", rd, (base & ~64'h7) + 64'(count) * 64'd8);
  endtask

  // FIFO source: presents data_arr[idx] up to fifo_limit words
  initial begin
    int idx;
    int seen;
    logic took;
    idx = 0;
    seen = 0;
    fifo_valid = 1'b0;
    fifo_data = 64'd0;
    forever begin
      @(negedge clock);
      took = fifo_valid && fifo_ready && !reset;
      @(posedge clock);
      #1;
      if (seen != job_gen) begin
        seen = job_gen;
        idx = 0;
      end else if (took) begin
        idx++;
      end
      fifo_valid = (idx < fifo_limit) && ($urandom_range(99) < fifo_gate_pct);
      fifo_data = data_arr[idx % 128];
    end
  end

  // Sink ready: 0 always, 1 random, 2 stall on a chosen word, 3 held low
  initial begin
    int seen;
    int left;
    seen = 0;
    left = 0;
    write_request_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (seen != job_gen) begin
        seen = job_gen;
        left = stall_len;
      end
      case (ready_mode)
        0: write_request_ready = 1'b1;
        1: write_request_ready = ($urandom_range(3) != 0);
        2: begin
          if (write_request_valid && acc_count == stall_at && left > 0) begin
            write_request_ready = 1'b0;
            left--;
          end else begin
            write_request_ready = 1'b1;
          end
        end
        default: write_request_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops on every accepted request, plus hold/backpressure rules
  initial begin
    logic pend;
    logic [63:0] pa, pd;
    req_t e;
    pend = 1'b0;
    pa = 64'd0;
    pd = 64'd0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (interrupt) int_count++;
        if (pend) begin
          check("hold_valid", {63'd0, write_request_valid}, 64'd1);
          check("hold_addr", write_request_address, pa);
          check("hold_data", write_request_data, pd);
        end
        if (write_request_valid && !write_request_ready)
          check("stall_fifo_ready", {63'd0, fifo_ready}, 64'd0);
        if (write_request_valid && write_request_ready) begin
          acc_count++;
          acc_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_request: got addr 0x%0h, required no request", write_request_address);
          end else begin
            e = exp_q.pop_front();
            check("req_addr", write_request_address, e.addr);
            check("req_data", write_request_data, e.data);
          end
        end
        pend = write_request_valid && !write_request_ready;
        pa = write_request_address;
        pd = write_request_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int ic0, a0, n;

    repeat (3) step();
    check("rst_valid", {63'd0, write_request_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_irq", {63'd0, interrupt}, 64'd0);
    check("rst_fifo_ready", {63'd0, fifo_ready}, 64'd0);
    check("rst_read_data", pio_read_data, 64'd0);
    check("rst_req_addr", write_request_address, 64'd0);
    check("rst_req_data", write_request_data, 64'd0);
    reset = 1'b0;
    step();
    pio_read(CTRL_A, rd);
    check("rst_status", rd, 64'd0);

    // Four back-to-back words from an unaligned base
    run_job(64'h0000_0000_1000_0003, 4, 0, 100);
    check("consecutive", 64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-4]), 64'd3);

    // Five-cycle stall on the second word
    stall_at = acc_count + 1;
    stall_len = 5;
    run_job({$urandom, $urandom}, 3, 2, 100);

    // Zero-length job completes immediately
    fifo_limit = 0;
    job_gen++;
    ic0 = int_count;
    pio_write(COUNT_A, 64'd0);
    pio_write(CTRL_A, 64'h5);
    check("zero_irq_early", {63'd0, interrupt}, 64'd0);
    step();
    check("zero_irq_pulse", {63'd0, interrupt}, 64'd1);
    step();
    check("zero_irq_end", {63'd0, interrupt}, 64'd0);
    repeat (2) step();
    check("zero_irq_count", 64'(int_count - ic0), 64'd1);
    pio_read(CTRL_A, rd);
    check("zero_status", rd, 64'h2);

    // Address wrap past 2^64
    run_job(64'hFFFF_FFFF_FFFF_FFF0, 3, 0, 100);

    for (int j = 0; j < 6; j++)
      run_job({$urandom, $urandom}, int'($urandom_range(20, 1)), 1, 70);

    // Abort after ten words with the tenth request still pending
    prepare_job(64'h0000_0002_0000_0000, 10);
    fifo_limit = 9;
    fifo_gate_pct = 100;
    ready_mode = 0;
    job_gen++;
    ic0 = int_count;
    a0 = acc_count;
    pio_write(BASE_A, 64'h0000_0002_0000_0000);
    pio_write(COUNT_A, 64'd100);
    pio_write(CTRL_A, 64'h5);
    n = 0;
    while (acc_count < a0 + 9 && n < 500) begin step(); n++; end
    check("abort_first9", 64'(acc_count - a0), 64'd9);
    ready_mode = 3;
    repeat (2) step();
    fifo_limit = 10;
    n = 0;
    while (!write_request_valid && n < 100) begin step(); n++; end
    check("abort_pending", {63'd0, write_request_valid}, 64'd1);
    step();
    pio_write(CTRL_A, 64'h2);
    fifo_limit = 100;
    ready_mode = 0;
    wait_idle(200);
    repeat (5) step();
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    check("abort_accepted", 64'(acc_count - a0), 64'd10);
    check("abort_no_irq", 64'(int_count - ic0), 64'd0);
    pio_read(CTRL_A, rd);
    check("abort_status", rd, {32'd10, 29'd0, 3'b100});
    pio_read(COUNT_A, rd);
    check("abort_remaining", rd, 64'd0);

    // Reset in the middle of a stalled run
    prepare_job(64'h0000_0000_0000_4000, 50);
    fifo_limit = 50;
    ready_mode = 3;
    job_gen++;
    ic0 = int_count;
    pio_write(BASE_A, 64'h4000);
    pio_write(COUNT_A, 64'd50);
    pio_write(CTRL_A, 64'h5);
    n = 0;
    while (!write_request_valid && n < 100) begin step(); n++; end
    check("mid_valid_before", {63'd0, write_request_valid}, 64'd1);
    step();
    reset = 1'b1;
    step();
    check("mid_valid_after", {63'd0, write_request_valid}, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_irq", {63'd0, interrupt}, 64'd0);
    check("mid_fifo_ready", {63'd0, fifo_ready}, 64'd0);
    check("mid_read_data", pio_read_data, 64'd0);
    reset = 1'b0;
    exp_q.delete();
    fifo_limit = 0;
    job_gen++;
    step();
    pio_read(CTRL_A, rd);
    check("mid_status", rd, 64'd0);
    pio_read(BASE_A, rd);
    check("mid_base", rd, 64'd0);
    pio_read(COUNT_A, rd);
    check("mid_count", rd, 64'd0);
    repeat (3) step();
    check("mid_no_irq", 64'(int_count - ic0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_write_sequencer.md
DMA_WRITE_SEQUENCER -- requirements
Module: dma_write_sequencer

Interface
REQ-001 Parameter REG_BASE, default 13'd16: first PIO register address; BASE=REG_BASE, COUNT=REG_BASE+1, CONTROL/STATUS=REG_BASE+2.
REQ-002 clock  input  1  sole clock; user clock of the PCIe core; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pio_write_valid  input  1  single-cycle PIO write strobe from the rx parser.
REQ-005 pio_read_valid  input  1  single-cycle PIO read strobe from the rx parser.
REQ-006 pio_address  input  13  64-bit-word PIO address, qualified by either strobe.
REQ-007 pio_write_data  input  64  PIO write payload.
REQ-008 pio_read_data  output  64  registered PIO read result.
REQ-009 fifo_data  input  64  source data word.
REQ-010 fifo_valid  input  1  fifo_data valid.
REQ-011 fifo_ready  output  1  word consumed when fifo_valid && fifo_ready.
REQ-012 write_request_valid  output  1  memory-write request to pcie_tx.
REQ-013 write_request_address  output  64  host byte address, 8-byte aligned.
REQ-014 write_request_data  output  64  write payload.
REQ-015 write_request_ready  input  1  pcie_tx accepts request this cycle.
REQ-016 busy  output  1  high in RUN.
REQ-017 interrupt  output  1  one-cycle completion pulse, for the cfg_interrupt request logic.

Function
REQ-018 PIO write to BASE loads the start address with bits [2:0] forced to 0; to COUNT loads word count from data[31:0]; both ignored while busy.
REQ-019 PIO write to CONTROL: bit0=start, bit1=abort, bit2=clear sticky status; other bits ignored.
REQ-020 PIO read: pio_read_data updates on the cycle after pio_read_valid; BASE returns current address, COUNT returns {32'd0, remaining}, STATUS returns {words_sent[31:0], 29'd0, aborted, done, busy}; other addresses leave pio_read_data unchanged.
REQ-021 States: IDLE, RUN, DONE. IDLE+start with COUNT!=0 -> RUN; IDLE+start with COUNT==0 -> DONE; start outside IDLE is ignored.
REQ-022 fifo_ready = RUN && remaining!=0 && (!write_request_valid || write_request_ready), combinational.
REQ-023 On a FIFO transfer, the next cycle has write_request_valid=1, data=fifo_data, address=current address; current address +=8; remaining -=1; words_sent +=1.
REQ-024 write_request_valid/address/data are held stable until write_request_ready; back-to-back transfers reach 1 word/cycle.
REQ-025 RUN -> DONE when remaining==0 and no request is pending (valid=0, or valid&&ready this cycle).
REQ-026 DONE lasts one cycle: interrupt=1, done sticky set; then -> IDLE.
REQ-027 Abort in RUN: remaining<=0 and aborted sticky set; a pending request stays valid until accepted; then -> IDLE with no interrupt and done unchanged.
REQ-028 Address arithmetic is 64-bit modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFF8 to 0 is legal and silent.
REQ-029 Start and clear in the same write: clear first, then start; clear resets done, aborted and words_sent.

Reset
REQ-030 Reset forces IDLE; write_request_valid, busy, interrupt, fifo_ready=0; address, remaining, words_sent, done, aborted, pio_read_data, write_request_address, write_request_data=0.
REQ-031 Reset mid-RUN drops write_request_valid on the next edge regardless of write_request_ready; no interrupt.

Structure
REQ-032 State encoding and the register offsets (0,1,2 from REG_BASE) and CONTROL bit positions live in a shared package, hififo_pkg.
REQ-033 Single flat module; no sub-modules.

Verification
REQ-034 BASE=0x1000_0003, COUNT=4, start, FIFO always valid, ready always 1 -> addresses 0x1000_0000/08/10/18 on 4 consecutive cycles, one interrupt pulse, STATUS=0x0000_0004_0000_0002.
REQ-035 COUNT=3, write_request_ready low for 5 cycles on word 2 -> address/data stable throughout, fifo_ready=0 during the stall, exactly 3 requests.
REQ-036 COUNT=0, start -> no requests, interrupt pulse 2 cycles after the strobe, done=1.
REQ-037 BASE=0xFFFF_FFFF_FFFF_FFF0, COUNT=3 -> addresses ...FFF0, ...FFF8, 0x0.
REQ-038 COUNT=100, abort after 10 words with a request pending -> that request is accepted, no further requests, aborted=1, no interrupt, words_sent=10.
REQ-039 Reset asserted mid-RUN with valid high and ready low -> valid=0 next cycle; all STATUS reads return 0.
